// File: rtl/ascii_dec_parser.sv
// ascii_dec_parser: parses ASCII decimal text from a UART receiver into an 8-bit value.
// Optional echo of the decoded byte through the UART transmitter when ASCII_DEC_PARSER_TX_EN is defined.
module ascii_dec_parser #(
    parameter int unsigned MAX_DIGITS = 3,
    parameter logic [7:0]  TERM_CR    = 8'h0D,
    parameter logic [7:0]  TERM_LF    = 8'h0A
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       tx_done,
    output logic       tx_start,
    output logic [7:0] tx_char,
    output logic [7:0] value,
    output logic       value_valid,
    output logic       err,
    output logic       busy
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ACC_W  = 10;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned EXT_W  = 14;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

`ifdef ASCII_DEC_PARSER_TX_EN
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACC     = 2'd1,
        ST_WAIT_TX = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1
    } state_t;
`endif

    state_t state_q;
    state_t state_d;

    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              ovf_q;
    logic              ovf_d;
    logic [DATA_W-1:0] value_q;
    logic [DATA_W-1:0] value_d;
    logic              value_valid_q;
    logic              value_valid_d;
    logic              err_q;
    logic              err_d;

    logic              is_digit;
    logic              is_term;
    logic [3:0]        digit;
    logic [EXT_W-1:0]  acc_ext;
    logic [CNT_W-1:0]  cnt_inc;
    logic              ovf_new;
    logic              accept;
    logic              drop;
    logic              commit;
    logic              commit_ovf;
    logic              commit_ok;
    logic              commit_bad;
    logic              reject;
    logic [DATA_W-1:0] commit_byte;

    // Byte classification and the candidate next accumulator value.
    assign is_digit    = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_term     = (rx_data == TERM_CR) || (rx_data == TERM_LF);
    assign digit       = 4'(rx_data - 8'h30);
    assign acc_ext     = EXT_W'(acc_q) * EXT_W'(10) + EXT_W'(digit);
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign ovf_new     = ovf_q | (acc_ext > EXT_W'(255));

`ifdef ASCII_DEC_PARSER_TX_EN
    assign accept      = rx_done && (state_q != ST_WAIT_TX);
    assign drop        = rx_done && (state_q == ST_WAIT_TX);
`else
    assign accept      = rx_done;
    assign drop        = 1'b0;
`endif

    assign commit      = accept && ((is_digit && (cnt_inc == CNT_MAX)) ||
                                    (is_term && (cnt_q != '0)));
    assign commit_ovf  = is_digit ? ovf_new : ovf_q;
    assign commit_ok   = commit && !commit_ovf;
    assign commit_bad  = commit && commit_ovf;
    assign reject      = accept && !is_digit && !is_term;
    assign commit_byte = is_digit ? acc_ext[DATA_W-1:0] : acc_q[DATA_W-1:0];

`ifdef ASCII_DEC_PARSER_TX_EN
    logic              tx_start_q;
    logic              tx_start_d;
    logic [DATA_W-1:0] tx_char_q;
    logic [DATA_W-1:0] tx_char_d;
    logic              busy_q;
    logic              busy_d;
`else
    logic unused_tx_done;
    assign unused_tx_done = tx_done;
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            acc_q         <= '0;
            cnt_q         <= '0;
            ovf_q         <= 1'b0;
            value_q       <= '0;
            value_valid_q <= 1'b0;
            err_q         <= 1'b0;
`ifdef ASCII_DEC_PARSER_TX_EN
            tx_start_q    <= 1'b0;
            tx_char_q     <= '0;
            busy_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            ovf_q         <= ovf_d;
            value_q       <= value_d;
            value_valid_q <= value_valid_d;
            err_q         <= err_d;
`ifdef ASCII_DEC_PARSER_TX_EN
            tx_start_q    <= tx_start_d;
            tx_char_q     <= tx_char_d;
            busy_q        <= busy_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_ACC: begin
                if (commit_ok) begin
`ifdef ASCII_DEC_PARSER_TX_EN
                    state_d = ST_WAIT_TX;
`else
                    state_d = ST_IDLE;
`endif
                end else if (commit_bad || reject) begin
                    state_d = ST_IDLE;
                end else if (accept && is_digit) begin
                    state_d = ST_ACC;
                end
            end
`ifdef ASCII_DEC_PARSER_TX_EN
            ST_WAIT_TX: begin
                if (tx_done) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values; every output leaves through a flop.
    always_comb begin
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        ovf_d         = ovf_q;
        value_d       = value_q;
        value_valid_d = 1'b0;
        err_d         = drop || reject || commit_bad;
`ifdef ASCII_DEC_PARSER_TX_EN
        tx_start_d    = 1'b0;
        tx_char_d     = tx_char_q;
        busy_d        = (state_d == ST_WAIT_TX);
`endif

        if (accept && is_digit) begin
            acc_d = ACC_W'(acc_ext);
            cnt_d = cnt_inc;
            ovf_d = ovf_new;
        end

        if (commit || reject) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end

        if (commit_ok) begin
            value_d       = commit_byte;
            value_valid_d = 1'b1;
`ifdef ASCII_DEC_PARSER_TX_EN
            tx_start_d    = 1'b1;
            tx_char_d     = commit_byte;
`endif
        end
    end

    assign value       = value_q;
    assign value_valid = value_valid_q;
    assign err         = err_q;
`ifdef ASCII_DEC_PARSER_TX_EN
    assign tx_start    = tx_start_q;
    assign tx_char     = tx_char_q;
    assign busy        = busy_q;
`else
    assign tx_start    = 1'b0;
    assign tx_char     = '0;
    assign busy        = 1'b0;
`endif

endmodule

// File: tb/tb_ascii_dec_parser.sv
// Self-checking bench for ascii_dec_parser: per-cycle vector table plus a short hand sequence.
// Expectations follow ASCII_DEC_PARSER_TX_EN when the bench is built with it.
module tb_ascii_dec_parser;

`ifdef ASCII_DEC_PARSER_TX_EN
    localparam bit TX = 1'b1;
`else
    localparam bit TX = 1'b0;
`endif

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_done;
    logic       tx_start;
    logic [7:0] tx_char;
    logic [7:0] value;
    logic       value_valid;
    logic       err;
    logic       busy;

    int total = 0;
    int bad   = 0;

    ascii_dec_parser dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .tx_done     (tx_done),
        .tx_start    (tx_start),
        .tx_char     (tx_char),
        .value       (value),
        .value_valid (value_valid),
        .err         (err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       rxv;
        logic [7:0] rxd;
        logic       txd;
        logic       vv;
        logic [7:0] val;
        logic       err;
        logic       ts;
        logic [7:0] tc;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [7:0] tcx(input logic [7:0] x);
        return TX ? x : 8'h00;
    endfunction

    task automatic add(input logic r, input logic rv, input logic [7:0] d, input logic t,
                       input logic vv, input logic [7:0] val, input logic e,
                       input logic ts, input logic [7:0] tc, input logic b);
        vec_t v;
        v.rst_n = r; v.rxv = rv; v.rxd = d; v.txd = t;
        v.vv = vv; v.val = val; v.err = e; v.ts = ts; v.tc = tc; v.busy = b;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One clock of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic r, input logic rv, input logic [7:0] d, input logic t);
        @(negedge clk);
        rst_n   = r;
        rx_done = rv;
        rx_data = d;
        tx_done = t;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic vv, input logic [7:0] val,
                             input logic e, input logic ts, input logic [7:0] tc, input logic b);
        chk({tag, " value_valid"}, 8'(value_valid), 8'(vv));
        chk({tag, " value"}, value, val);
        chk({tag, " err"}, 8'(err), 8'(e));
        chk({tag, " tx_start"}, 8'(tx_start), 8'(ts));
        chk({tag, " tx_char"}, tx_char, tc);
        chk({tag, " busy"}, 8'(busy), 8'(b));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rx_done = 1'b0; rx_data = 8'h00; tx_done = 1'b0;

        //   rst  rxv  rxd    txd   vv  value                 err  ts  tx_char              busy
        add(0, 0, 8'h00, 0,  0, 8'h00,               0,  0, 8'h00,             0);
        add(1, 1, "6",   0,  0, 8'h00,               0,  0, 8'h00,             0);
        add(1, 1, "5",   0,  0, 8'h00,               0,  0, 8'h00,             0);
        add(1, 1, CR,    0,  1, 8'h41,               0,  TX, tcx(8'h41),       TX);
        add(1, 0, 8'h00, 0,  0, 8'h41,               0,  0, tcx(8'h41),        TX);
        add(1, 0, 8'h00, 1,  0, 8'h41,               0,  0, tcx(8'h41),        0);
        // 255 auto-commits on the third digit; the trailing CR is silent
        add(1, 1, "2",   0,  0, 8'h41,               0,  0, tcx(8'h41),        0);
        add(1, 1, "5",   0,  0, 8'h41,               0,  0, tcx(8'h41),        0);
        add(1, 1, "5",   0,  1, 8'hFF,               0,  TX, tcx(8'hFF),       TX);
        add(1, 0, 8'h00, 1,  0, 8'hFF,               0,  0, tcx(8'hFF),        0);
        add(1, 1, CR,    0,  0, 8'hFF,               0,  0, tcx(8'hFF),        0);
        add(1, 1, "2",   0,  0, 8'hFF,               0,  0, tcx(8'hFF),        0);
        add(1, 1, "5",   0,  0, 8'hFF,               0,  0, tcx(8'hFF),        0);
        add(1, 1, "6",   0,  0, 8'hFF,               1,  0, tcx(8'hFF),        0);
        add(1, 1, "9",   0,  0, 8'hFF,               0,  0, tcx(8'hFF),        0);
        add(1, 1, "9",   0,  0, 8'hFF,               0,  0, tcx(8'hFF),        0);
        add(1, 1, "9",   0,  0, 8'hFF,               1,  0, tcx(8'hFF),        0);
        add(1, 1, "1",   0,  0, 8'hFF,               0,  0, tcx(8'hFF),        0);
        add(1, 1, "x",   0,  0, 8'hFF,               1,  0, tcx(8'hFF),        0);
        add(1, 1, "3",   0,  0, 8'hFF,               0,  0, tcx(8'hFF),        0);
        add(1, 1, LF,    0,  1, 8'h03,               0,  TX, tcx(8'h03),       TX);
        add(1, 0, 8'h00, 1,  0, 8'h03,               0,  0, tcx(8'h03),        0);
        add(1, 1, "0",   0,  0, 8'h03,               0,  0, tcx(8'h03),        0);
        add(1, 1, "0",   0,  0, 8'h03,               0,  0, tcx(8'h03),        0);
        add(1, 1, "7",   0,  1, 8'h07,               0,  TX, tcx(8'h07),       TX);
        add(1, 0, 8'h00, 1,  0, 8'h07,               0,  0, tcx(8'h07),        0);
        add(1, 1, CR,    0,  0, 8'h07,               0,  0, tcx(8'h07),        0);
        // byte during the transmit wait is dropped only when TX is built in
        add(1, 1, "8",   0,  0, 8'h07,               0,  0, tcx(8'h07),        0);
        add(1, 1, CR,    0,  1, 8'h08,               0,  TX, tcx(8'h08),       TX);
        add(1, 1, "7",   0,  0, 8'h08,               TX, 0, tcx(8'h08),        TX);
        add(1, 0, 8'h00, 1,  0, 8'h08,               0,  0, tcx(8'h08),        0);
        add(1, 1, CR,    0,  !TX, TX ? 8'h08 : 8'h07, 0, 0, tcx(8'h08),        0);
        add(1, 1, "8",   0,  0, TX ? 8'h08 : 8'h07,  0,  0, tcx(8'h08),        0);
        add(1, 1, CR,    0,  1, 8'h08,               0,  TX, tcx(8'h08),       TX);
        add(1, 1, "5",   1,  0, 8'h08,               TX, 0, tcx(8'h08),        0);
        add(1, 1, CR,    0,  !TX, TX ? 8'h08 : 8'h05, 0, 0, tcx(8'h08),        0);
        add(1, 1, "1",   0,  0, TX ? 8'h08 : 8'h05,  0,  0, tcx(8'h08),        0);
        add(1, 1, CR,    0,  1, 8'h01,               0,  TX, tcx(8'h01),       TX);
        add(1, 0, 8'h00, 1,  0, 8'h01,               0,  0, tcx(8'h01),        0);
        // reset aborts a partial number and a pending transmit
        add(1, 1, "4",   0,  0, 8'h01,               0,  0, tcx(8'h01),        0);
        add(0, 0, 8'h00, 0,  0, 8'h00,               0,  0, 8'h00,             0);
        add(1, 1, "2",   0,  0, 8'h00,               0,  0, 8'h00,             0);
        add(1, 1, CR,    0,  1, 8'h02,               0,  TX, tcx(8'h02),       TX);
        add(1, 0, 8'h00, 1,  0, 8'h02,               0,  0, tcx(8'h02),        0);
        add(1, 1, "3",   0,  0, 8'h02,               0,  0, tcx(8'h02),        0);
        add(1, 1, CR,    0,  1, 8'h03,               0,  TX, tcx(8'h03),       TX);
        add(0, 0, 8'h00, 0,  0, 8'h00,               0,  0, 8'h00,             0);
        add(1, 1, "1",   0,  0, 8'h00,               0,  0, 8'h00,             0);
        add(1, 1, CR,    0,  1, 8'h01,               0,  TX, tcx(8'h01),       TX);
        add(1, 0, 8'h00, 1,  0, 8'h01,               0,  0, tcx(8'h01),        0);

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].rxv, vecs[i].rxd, vecs[i].txd);
            check_all($sformatf("vec%0d", i), vecs[i].vv, vecs[i].val, vecs[i].err,
                      vecs[i].ts, vecs[i].tc, vecs[i].busy);
        end

        // Hand sequence: 128 auto-commit, single-cycle strobes, tx_char held while busy.
        step(1, 1, "1", 0);
        step(1, 1, "2", 0);
        step(1, 1, "8", 0);
        check_all("seq commit", 1, 8'h80, 0, TX, tcx(8'h80), TX);
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 8'h00, 0);
            check_all($sformatf("seq hold%0d", k), 0, 8'h80, 0, 0, tcx(8'h80), TX);
        end
        step(1, 0, 8'h00, 1);
        check_all("seq txdone", 0, 8'h80, 0, 0, tcx(8'h80), 0);
        step(1, 0, 8'h00, 1);
        check_all("seq stray txdone", 0, 8'h80, 0, 0, tcx(8'h80), 0);
        step(1, 1, "9", 0);
        step(1, 1, LF, 0);
        check_all("seq lf commit", 1, 8'h09, 0, TX, tcx(8'h09), TX);
        step(1, 0, 8'h00, 0);
        check_all("seq lf strobe end", 0, 8'h09, 0, 0, tcx(8'h09), TX);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ascii_dec_parser.md
# ascii_dec_parser

Receive-side counterpart of the byte-to-decimal UART echo path. Consumes bytes from `uart_rx` (`dout` / `rx_done_tick`) and parses ASCII decimal text such as `65<CR>` into an 8-bit value. Presents the value on a parallel port with a valid strobe. Optionally sends the decoded byte back out through `uart_tx` using its `tx_start` / `tx_done_tick` handshake.

## Interface
- `MAX_DIGITS`, default 3: digit count that forces an automatic commit; legal range 1–3.
- `TERM_CR`, default 8'h0D: primary terminator character.
- `TERM_LF`, default 8'h0A: secondary terminator character.

Ports:
- `clk` input 1: system clock; the single clock domain.
- `rst_n` input 1: reset, synchronous, active-low.
- `rx_data` input 8: received byte; valid when `rx_done` is high.
- `rx_done` input 1: one-cycle strobe per received byte.
- `tx_done` input 1: one-cycle strobe from the transmitter at end of a frame.
- `tx_start` output 1: one-cycle request to the transmitter.
- `tx_char` output 8: byte to transmit; held stable from `tx_start` until `tx_done`.
- `value` output 8: last committed value; holds between commits.
- `value_valid` output 1: one-cycle strobe on commit.
- `err` output 1: one-cycle strobe on a rejected byte or a rejected number.
- `busy` output 1: high while waiting for `tx_done`.

## Operation
- States: IDLE (no digits held), ACC (1 to MAX_DIGITS−1 digits held), WAIT_TX (decoded byte in flight).
- Accumulator `acc` is 10 bits; digit counter `cnt` is 2 bits; `ovf` is a sticky overflow flag.
- Digit byte (8'h30–8'h39) in IDLE or ACC:
  - `acc <= acc*10 + (rx_data - 8'h30)` and `cnt <= cnt+1`.
  - Set `ovf` if the new `acc` exceeds 255.
  - Go to ACC.
- Commit condition: a terminator byte with `cnt ≥ 1`, or a digit byte that makes `cnt == MAX_DIGITS`.
- Commit with `ovf == 0`:
  - `value <= acc[7:0]` and `value_valid` pulses.
  - If TX is enabled: `tx_char <= acc[7:0]`, `tx_start` pulses, go to WAIT_TX.
  - If TX is disabled: go to IDLE.
  - Clear `acc`, `cnt` and `ovf`.
- Commit with `ovf == 1`:
  - `err` pulses; `value` is unchanged; no TX.
  - Clear `acc`, `cnt` and `ovf`; go to IDLE.
- Terminator in IDLE (`cnt == 0`): ignored, with no `err`. This covers CR LF pairs and a CR following an auto-commit.
- Any other byte in IDLE or ACC: `err` pulses; clear `acc`, `cnt` and `ovf`; go to IDLE.
- WAIT_TX:
  - `busy` = 1.
  - Any `rx_done` is dropped and `err` pulses.
  - On `tx_done`, go to IDLE.
- Leading zeros are legal: `007<CR>` yields 7, and `007` alone auto-commits 7.

## Timing
- Reset values:
  - `tx_start`, `value_valid`, `err`, `busy`: 0.
  - `tx_char`, `value`: 8'h00.
  - `acc`, `cnt`, `ovf`: 0.
  - State: IDLE.
- Reset takes effect on the first `clk` edge with `rst_n` low. It aborts any partial number or pending TX.
- All outputs are registered.
- `value_valid` and `tx_start` assert in the same cycle, one cycle after the `rx_done` that caused the commit.
- `err` asserts one cycle after the offending `rx_done`.
- `busy` rises with `tx_start` and falls one cycle after `tx_done`.
- `rx_done` and `tx_done` in the same WAIT_TX cycle: the state goes to IDLE and the rx byte is still dropped with `err`.
- `tx_done` outside WAIT_TX: ignored.
- `rx_done` strobes can arrive as close as one per cycle; each is processed in order with no loss outside WAIT_TX.

## Configuration
- Macro `ASCII_DEC_PARSER_TX_EN`.
- Defined: commit launches the TX handshake; the WAIT_TX state and `busy` behave as described.
- Undefined:
  - WAIT_TX is removed.
  - `tx_start`, `busy` and `tx_char` are tied to 0.
  - `tx_done` is ignored.
  - Commits return straight to IDLE, so no bytes are ever dropped for busy.

## Test plan
- `'6','5',8'h0D` → `value_valid` one cycle after the CR with `value = 8'h41`; `tx_start` with `tx_char = 8'h41`; `busy` until `tx_done`.
- `'2','5','5'` with no terminator → auto-commit on the third digit with `value = 8'hFF`. A following CR gives no `value_valid` and no `err`.
- `'2','5','6'` → `err` pulse; `value` keeps its previous value; no `tx_start`. Repeat with `'9','9','9'`: same result.
- `'1','x'` → `err` one cycle after `'x'`. Then `'3',8'h0A` → `value = 8'h03`.
- During WAIT_TX, send `'7'` → `err`; after `tx_done`, send `'8',8'h0D` → `value = 8'h08`. Also drive `rx_done` and `tx_done` in the same cycle → `err`, and the state returns to IDLE.
- `'4'`, then `rst_n` low for one cycle, then `'2',8'h0D` → `value = 8'h02`, not 42. With the macro undefined, rerun the first scenario: `value_valid` occurs and `tx_start` stays 0.
